// File: rtl/gate_tester.sv
// Stimulus/capture wrapper for the AND/OR/NOT gate block: walks all four
// A/B patterns, holds each for DWELL cycles and records per-pattern faults.
module gate_tester #(
    parameter int DWELL = 40,
    parameter int CNT_W = 8
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic       iAnd,
    input  logic       iOr,
    input  logic       iNot,
    output logic       oA,
    output logic       oB,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic [3:0] oFailVec,
    output logic [2:0] oErrCnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state, stateNxt;
    logic [1:0]       idx, idxNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic             aNxt, bNxt, busyNxt, doneNxt, passNxt;
    logic [3:0]       failNxt;
    logic [2:0]       errNxt;
    logic             lastCycle;
    logic             mismatch;

    assign lastCycle = (cnt == LAST);

    // oA/oB always hold the pattern for idx while driving
    assign mismatch = (iAnd != (oA & oB)) ||
                      (iOr  != (oA | oB)) ||
                      (iNot != ~oA);

    always_comb begin
        stateNxt = state;
        idxNxt   = idx;
        cntNxt   = cnt;
        aNxt     = oA;
        bNxt     = oB;
        busyNxt  = oBusy;
        doneNxt  = oDone;
        passNxt  = oPass;
        failNxt  = oFailVec;
        errNxt   = oErrCnt;
        unique case (state)
            IDLE, DONE: begin
                if (iStart) begin
                    stateNxt = DRIVE;
                    idxNxt   = 2'd0;
                    cntNxt   = '0;
                    failNxt  = 4'd0;
                    errNxt   = 3'd0;
                    doneNxt  = 1'b0;
                    passNxt  = 1'b0;
                    busyNxt  = 1'b1;
                    aNxt     = 1'b0;
                    bNxt     = 1'b0;
                end
            end
            DRIVE: begin
                cntNxt = cnt + 1'b1;
                if (lastCycle) begin
                    if (mismatch) begin
                        failNxt[idx] = 1'b1;
                        errNxt       = oErrCnt + 3'd1;
                    end
                    cntNxt = '0;
                    if (idx == 2'd3) begin
                        stateNxt = DONE;
                        idxNxt   = 2'd0;
                        busyNxt  = 1'b0;
                        doneNxt  = 1'b1;
                        passNxt  = (failNxt == 4'd0);
                        aNxt     = 1'b0;
                        bNxt     = 1'b0;
                    end else begin
                        idxNxt = idx + 2'd1;
                        aNxt   = idxNxt[0];
                        bNxt   = idxNxt[1];
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            cnt      <= '0;
            oA       <= 1'b0;
            oB       <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oPass    <= 1'b0;
            oFailVec <= 4'd0;
            oErrCnt  <= 3'd0;
        end else begin
            state    <= stateNxt;
            idx      <= idxNxt;
            cnt      <= cntNxt;
            oA       <= aNxt;
            oB       <= bNxt;
            oBusy    <= busyNxt;
            oDone    <= doneNxt;
            oPass    <= passNxt;
            oFailVec <= failNxt;
            oErrCnt  <= errNxt;
        end
    end

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: a long-dwell and a short-dwell instance, each
// wrapped around a behavioural gate with injectable per-pattern faults.
module tb_gate_tester;

    localparam int DL = 40;
    localparam int DS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   sel;

    logic       startL, aL, bL, busyL, doneL, passL, andL, orL, notL, glitchL;
    logic [3:0] fvL;
    logic [2:0] ecL;
    logic [2:0] faultL [4];

    logic       startS, aS, bS, busyS, doneS, passS, andS, orS, notS;
    logic [3:0] fvS;
    logic [2:0] ecS;
    logic [2:0] faultS [4];

    // gate under test: correct truth table xor'd with the injected fault
    assign andL = (aL & bL) ^ faultL[{bL, aL}][0] ^ glitchL;
    assign orL  = (aL | bL) ^ faultL[{bL, aL}][1] ^ glitchL;
    assign notL = (~aL)     ^ faultL[{bL, aL}][2] ^ glitchL;
    assign andS = (aS & bS) ^ faultS[{bS, aS}][0];
    assign orS  = (aS | bS) ^ faultS[{bS, aS}][1];
    assign notS = (~aS)     ^ faultS[{bS, aS}][2];

    gate_tester #(.DWELL(DL), .CNT_W(8)) uLong (
        .iClk(clk), .iRst(rst), .iStart(startL),
        .iAnd(andL), .iOr(orL), .iNot(notL),
        .oA(aL), .oB(bL), .oBusy(busyL), .oDone(doneL), .oPass(passL),
        .oFailVec(fvL), .oErrCnt(ecL)
    );

    gate_tester #(.DWELL(DS), .CNT_W(4)) uShort (
        .iClk(clk), .iRst(rst), .iStart(startS),
        .iAnd(andS), .iOr(orS), .iNot(notS),
        .oA(aS), .oB(bS), .oBusy(busyS), .oDone(doneS), .oPass(passS),
        .oFailVec(fvS), .oErrCnt(ecS)
    );

    logic       mA, mB, mBusy, mDone, mPass;
    logic [3:0] mFv;
    logic [2:0] mEc;
    always_comb begin
        mA    = (sel != 0) ? aS    : aL;
        mB    = (sel != 0) ? bS    : bL;
        mBusy = (sel != 0) ? busyS : busyL;
        mDone = (sel != 0) ? doneS : doneL;
        mPass = (sel != 0) ? passS : passL;
        mFv   = (sel != 0) ? fvS   : fvL;
        mEc   = (sel != 0) ? ecS   : ecL;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic setStart(input logic v);
        if (sel != 0) startS = v;
        else startL = v;
    endtask

    // one full run; f holds {not,or,and} fault bits for patterns 3..0
    task automatic runCase(input int s, input logic [11:0] f,
                           input bit extra, input bit glitch);
        int         d;
        int         p;
        int         expEc;
        logic [3:0] expFv;
        sel   = s;
        d     = (s != 0) ? DS : DL;
        expEc = 0;
        for (int i = 0; i < 4; i++) begin
            if (s != 0) faultS[i] = f[i*3 +: 3];
            else faultL[i] = f[i*3 +: 3];
            expFv[i] = |f[i*3 +: 3];
            expEc += int'(expFv[i]);
        end
        @(negedge clk);
        setStart(1'b1);
        @(posedge clk);
        #1;
        setStart(1'b0);
        check("startBusy", 32'(mBusy), 32'd1);
        check("startDone", 32'(mDone), 32'd0);
        check("startPass", 32'(mPass), 32'd0);
        check("startFv", 32'(mFv), 32'd0);
        check("startEc", 32'(mEc), 32'd0);
        check("startAB", 32'({mB, mA}), 32'd0);
        for (int e = 1; e <= 4 * d; e++) begin
            @(posedge clk);
            #1;
            setStart(1'b0);
            glitchL = 1'b0;
            if (e < 4 * d) begin
                if (e % d == d / 2) begin
                    p = e / d;
                    check("patAB", 32'({mB, mA}), 32'(p));
                    check("patBusy", 32'(mBusy), 32'd1);
                end
                if (e == 4 * d - 1)
                    check("preDone", 32'(mDone), 32'd0);
                if (glitch && s == 0 && e % d == 10)
                    glitchL = 1'b1;
                if (extra && s == 0 && (e == 15 || e == 95))
                    setStart(1'b1);
            end else begin
                check("endDone", 32'(mDone), 32'd1);
                check("endBusy", 32'(mBusy), 32'd0);
                check("endPass", 32'(mPass), 32'(expFv == 4'd0));
                check("endFv", 32'(mFv), 32'(expFv));
                check("endEc", 32'(mEc), 32'(expEc));
                check("endAB", 32'({mB, mA}), 32'd0);
            end
        end
    endtask

    logic [11:0] rf;

    initial begin
        rst = 1'b1;
        sel = 0;
        startL = 1'b0;
        startS = 1'b0;
        glitchL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            faultL[i] = 3'd0;
            faultS[i] = 3'd0;
        end
        #12;
        check("rstL", 32'({aL, bL, busyL, doneL, passL, fvL, ecL}), 32'd0);
        check("rstS", 32'({aS, bS, busyS, doneS, passS, fvS, ecS}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // correct gate, then stuck-at-0 AND, then NOT wired to A
        runCase(0, 12'h000, 1'b0, 1'b1);
        runCase(0, 12'h200, 1'b0, 1'b0);
        runCase(0, 12'h924, 1'b0, 1'b0);
        // stray starts mid-run are ignored
        runCase(0, 12'h000, 1'b1, 1'b1);

        // reset mid-run
        sel = 0;
        for (int i = 0; i < 4; i++) faultL[i] = 3'd0;
        @(negedge clk);
        startL = 1'b1;
        @(posedge clk);
        #1;
        startL = 1'b0;
        repeat (65) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midRst", 32'({aL, bL, busyL, doneL, passL, fvL, ecL}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("postRst", 32'({busyL, doneL}), 32'd0);
        runCase(0, 12'h000, 1'b0, 1'b0);

        // reset and start together: reset wins
        @(negedge clk);
        rst = 1'b1;
        startS = 1'b1;
        @(posedge clk);
        #1;
        check("rstWins", 32'({busyS, doneS}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        startS = 1'b0;

        // short dwell: random faults, back-to-back restarts from DONE
        runCase(1, 12'h000, 1'b0, 1'b0);
        runCase(1, 12'h040, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            rf = 12'd0;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 1) == 1)
                    rf[i*3 +: 3] = 3'($urandom_range(1, 7));
            runCase(1, rf, 1'b0, 1'b0);
        end
        runCase(1, 12'h000, 1'b0, 1'b0);

        // a couple of random long-dwell runs with glitches
        for (int n = 0; n < 2; n++) begin
            rf = 12'($urandom_range(0, 4095));
            runCase(0, rf, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_tester.md
# gate_tester

Self-checking stimulus and capture stage wrapped around the two-input logic-gate block (AND/OR/NOT). It drives the gate's A/B inputs through all four input combinations and holds each one for a programmable number of clock cycles. At the end of each hold it samples the gate's three outputs and compares them with the expected truth table. It sits directly upstream (stimulus) and downstream (result capture) of the gate block, and reports a per-pattern failure vector and a pass flag on completion.

## Interface
- DWELL, 40: clock cycles each input pattern is held; legal range 2..255.
- CNT_W, 8: width of the dwell counter; must satisfy 2^CNT_W > DWELL.

- iClk  input  1  system clock; everything updates on the rising edge.
- iRst  input  1  reset; asynchronous and active-high.
- iStart  input  1  run request; sampled on the rising edge of iClk.
- iAnd  input  1  AND output of the gate under test.
- iOr  input  1  OR output of the gate under test.
- iNot  input  1  NOT output of the gate under test (inverts A).
- oA  output  1  A stimulus to the gate under test.
- oB  output  1  B stimulus to the gate under test.
- oBusy  output  1  high while a run is in progress.
- oDone  output  1  high after a run completes; stays high until the next run starts.
- oPass  output  1  1 when oDone=1 and no pattern failed; 0 at all other times.
- oFailVec  output  4  bit i set means pattern i mismatched.
- oErrCnt  output  3  number of failing patterns, 0..4.

## Operation
- Pattern order, as index: (A,B)
  - 0: (0,0)
  - 1: (1,0)
  - 2: (0,1)
  - 3: (1,1)
- Expected outputs for each pattern:
  - And = A&B
  - Or = A|B
  - Not = ~A
- FSM states are IDLE, DRIVE and DONE.
- IDLE:
  - oA=oB=0 and oBusy=0.
  - iStart=1 moves to DRIVE. On the same edge: idx=0, cnt=0, oFailVec=0, oErrCnt=0, oDone=0, and oA/oB take pattern 0.
- DRIVE:
  - oBusy=1; oA/oB hold pattern idx; cnt increments every cycle.
  - On the edge where cnt==DWELL-1, the design samples iAnd/iOr/iNot and compares them with the expected values for idx.
  - On a mismatch of any of the three outputs, oFailVec[idx] is set and oErrCnt increments, both on that same edge.
  - If idx<3: idx increments, cnt returns to 0, and oA/oB take the next pattern on that same edge.
  - If idx==3: go to DONE.
- DONE:
  - oBusy=0, oDone=1, oA=oB=0.
  - oPass = (oFailVec==0).
  - oFailVec and oErrCnt hold their values.
  - iStart=1 starts a new run with exactly the IDLE→DRIVE actions above.
- iStart while in DRIVE is ignored; the run is neither restarted nor extended.
- Exactly one comparison is made per pattern. Glitches on iAnd/iOr/iNot before the sample cycle are not recorded.
- All outputs are registered; no output has a combinational path from any input.

## Timing
- Reset values: state=IDLE, oA=0, oB=0, oBusy=0, oDone=0, oPass=0, oFailVec=0, oErrCnt=0, idx=0, cnt=0.
- Reset takes effect immediately, without waiting for a clock edge.
- Reset during DRIVE aborts the run: no partial result is kept and oDone does not assert.
- iStart sampled high at edge k:
  - oBusy=1 and pattern 0 is on oA/oB from edge k.
  - Pattern p is driven during edges k+p·DWELL .. k+(p+1)·DWELL−1.
  - The sample for pattern p is taken at edge k+(p+1)·DWELL−1.
- oDone, oPass, the final oFailVec and the final oErrCnt are valid from edge k+4·DWELL. A run therefore takes 4·DWELL cycles from start to done.
- The gate under test sees at least DWELL−1 full cycles of stable input before each sample.
- The final compare (pattern 3) and the DRIVE→DONE transition happen on the same edge. oErrCnt already includes the pattern-3 result when oDone rises.
- iRst and iStart asserted together: reset wins.

## Test plan
- **Correct gate, DWELL=40, iStart pulsed at cycle 5**
  - oA/oB step 00→10→01→11 at cycles 5, 45, 85, 125.
  - oDone=1 and oPass=1 at cycle 165, with oFailVec=0000 and oErrCnt=0.
- **Gate with iAnd stuck at 0**
  - Only pattern 3 fails: oFailVec=1000, oErrCnt=1, oPass=0, oDone=1.
- **Gate with iNot driven as A instead of ~A**
  - Every pattern fails: oFailVec=1111, oErrCnt=4, oPass=0.
- **Extra iStart pulses at cycles 20 and 100 during a run started at cycle 5**
  - No restart: oDone still rises at cycle 165 and the results match the correct-gate case.
- **iRst asserted at cycle 70 between clock edges, mid-run**
  - All outputs go to 0 immediately, with no wait for a clock edge.
  - A new iStart at cycle 80 gives a full run with oDone at cycle 240.
- **DWELL=2, correct gate; restart from DONE**
  - oDone at start+8.
  - A second iStart while oDone=1 clears oDone and oFailVec on that edge.
  - The second run completes again 8 cycles later with oPass=1.
